// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands two bits per clock through one shared 2-bit add slice
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int STEPS = WIDTH / 2;
  localparam int KW = $clog2(STEPS) + 1;
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_sum, w_acc;
  logic [KW-1:0] r_k;
  logic [IW-1:0] w_idx;
  logic [2:0] w_slice;
  logic r_carry, r_cout, w_last;
  assign w_idx = IW'({r_k, 1'b0});
  assign w_slice = {1'b0, r_a[w_idx +: 2]} + {1'b0, r_b[w_idx +: 2]} + {2'b0, r_carry};
  assign w_last = r_k == KW'(STEPS - 1);
  // accumulator with the current pair merged in, so the last step can publish it directly
  always_comb begin
    w_acc = r_acc;
    w_acc[w_idx +: 2] = w_slice[1:0];
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (start ? RUN : IDLE) :
             r_state == RUN  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_acc <= '0;
      r_sum <= '0;
      r_k <= '0;
      r_carry <= 1'b0;
      r_cout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_a <= a;
        r_b <= b;
        r_carry <= cin;
        r_k <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_acc;
        r_carry <= w_slice[2];
        r_k <= r_k + KW'(1);
        if (w_last) begin
          r_sum <= w_acc;
          r_cout <= w_slice[2];
        end
      end
    end
  end
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  assign sum = r_sum;
  assign cout = r_cout;
endmodule
